// File: rtl/wb_write_sequencer_pkg.sv
// Shared types and constants for the write-back sequencer: register index width,
// the default-width FIFO entry record and the occupancy classes derived from count.
package wb_write_sequencer_pkg;

  localparam int REG_IDX_W = 2;
  localparam int WB_DATA_W = 8;

  typedef struct packed {
    logic [REG_IDX_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_t;

  function automatic occ_t occ_of(int unsigned cnt, int unsigned depth);
    if (cnt == 0)          return EMPTY;
    else if (cnt >= depth) return FULL;
    else                   return PARTIAL;
  endfunction

endpackage

// File: rtl/wb_write_sequencer_if.sv
// Request, issue and lookup signals of the write-back sequencer.
// The slave modport is the sequencer; the master modport is whoever feeds and observes it.
interface wb_write_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
);
  import wb_write_sequencer_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [REG_IDX_W-1:0] in_addr;
  logic [DATA_W-1:0]    in_data;
  logic                 hold;
  logic                 wr_en;
  logic [REG_IDX_W-1:0] wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic [CNT_W-1:0]     count;
  logic [REG_IDX_W-1:0] lk_addr;
  logic                 lk_hit;
  logic [DATA_W-1:0]    lk_data;

  modport master (
    output in_valid, in_addr, in_data, hold, lk_addr,
    input  in_ready, wr_en, wr_addr, wr_data, count, lk_hit, lk_data
  );

  modport slave (
    input  in_valid, in_addr, in_data, hold, lk_addr,
    output in_ready, wr_en, wr_addr, wr_data, count, lk_hit, lk_data
  );

endinterface

// File: rtl/wb_write_sequencer_fifo_ptr.sv
// Read/write pointer and occupancy tracking for the sequencer FIFO.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo_ptr
  import wb_write_sequencer_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [CNT_W-1:0] count,
  output occ_t             occ
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign occ     = occ_of(32'(count_q), DEPTH);
  assign push_ok = push && (occ != FULL);
  assign pop_ok  = pop && (occ != EMPTY);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_ptr = rd_ptr_q;
  assign wr_ptr = wr_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/wb_write_sequencer.sv
// Write-back sequencer feeding the 2-to-4 register-select decoder from a small FIFO.
// Define WB_SEQ_LOOKUP_EN to build the pending-write lookup port; otherwise lk_hit/lk_data tie to 0.
module wb_write_sequencer
  import wb_write_sequencer_pkg::*;
#(
  parameter  int DATA_W = WB_DATA_W,
  parameter  int DEPTH  = 2,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input logic                 clk,
  input logic                 reset,
  wb_write_sequencer_if.slave bus
);

  typedef struct packed {
    logic [REG_IDX_W-1:0] addr;
    logic [DATA_W-1:0]    data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  occ_t             occ;
  logic             push, pop;

  wb_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk    (clk),
    .rst    (reset),
    .push   (push),
    .pop    (pop),
    .rd_ptr (rd_ptr),
    .wr_ptr (wr_ptr),
    .count  (count),
    .occ    (occ)
  );

  // in_ready ignores hold and same-cycle pops: a full FIFO never accepts.
  assign bus.in_ready = (occ != FULL);
  assign push         = bus.in_valid && (occ != FULL);
  assign pop          = (occ != EMPTY) && !bus.hold;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = '{addr: bus.in_addr, data: bus.in_data};
  end

  // Entry storage is left uncleared by reset; validity comes from count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head        = mem_q[rd_ptr];
  assign bus.wr_en   = pop;
  assign bus.wr_addr = pop ? head.addr : '0;
  assign bus.wr_data = pop ? head.data : '0;
  assign bus.count   = count;

`ifdef WB_SEQ_LOOKUP_EN
  logic [PTR_W-1:0] lk_idx;

  // Walk oldest to youngest so the last match is the youngest entry.
  always_comb begin
    bus.lk_hit  = 1'b0;
    bus.lk_data = '0;
    lk_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (mem_q[lk_idx].addr == bus.lk_addr)) begin
        bus.lk_hit  = 1'b1;
        bus.lk_data = mem_q[lk_idx].data;
      end
    end
  end
`else
  assign bus.lk_hit  = 1'b0;
  assign bus.lk_data = '0;
`endif

endmodule

// File: doc/wb_write_sequencer.md
Name: wb_write_sequencer

Overview:
- Write-back sequencer that sits directly upstream of the 2-to-4 register-select decoder.
- Accepts register write requests (address, data) over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one write per cycle as enable + 2-bit address, which drive the decoder's enable and select inputs, plus a data bus to the register bank.
- Provides a lookup port that reports whether a pending, not-yet-issued write targets a given register.

Parameters:
- DATA_W, 8, width of write data.
- DEPTH, 2, FIFO entries; power of two, legal values 2 or 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  write request valid.
- in_ready  out  1  sequencer can accept a request.
- in_addr  in  2  destination register index.
- in_data  in  DATA_W  write data.
- hold  in  1  downstream stall; no issue while high.
- wr_en  out  1  write issued this cycle; drives decoder enable.
- wr_addr  out  2  register index; drives decoder select.
- wr_data  out  DATA_W  write data to register bank.
- count  out  $clog2(DEPTH)+1  current occupancy.
- lk_addr  in  2  lookup register index.
- lk_hit  out  1  a pending entry targets lk_addr.
- lk_data  out  DATA_W  data of the youngest matching entry.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset clears the read pointer, write pointer and count. Entry storage is not cleared.
- Outputs while reset is asserted or after it: in_ready=1, wr_en=0, wr_addr=0, wr_data=0, count=0, lk_hit=0, lk_data=0.
- Occupancy states, derived from count:
  - EMPTY (count=0)
  - PARTIAL (0<count<DEPTH)
  - FULL (count=DEPTH)
- Push: occurs when in_valid && in_ready at a rising edge. in_ready = (count != DEPTH). in_ready does not depend on hold or on a same-cycle pop.
- Issue: combinational from the FIFO head.
  - wr_en = (count != 0) && !hold.
  - When wr_en=1: wr_addr/wr_data = head entry, and the pop takes effect at the next edge.
  - When wr_en=0: wr_addr and wr_data are driven 0. The decoder's select lines are then all inactive (high).
- Latency: a request accepted at edge N is issued no earlier than the cycle after edge N. There is no empty-FIFO bypass. Requests are issued in strict FIFO order.
- Simultaneous push and pop in PARTIAL: both happen; count is unchanged.
- In FULL with pop: in_ready stays 0 that cycle, so no push occurs.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- hold is sampled every cycle. Raising hold freezes the head with wr_en=0. Lowering it resumes issue in the same cycle.
- Asserting reset mid-operation discards all pending entries immediately. No write is issued for them.
- Lookup: combinational over all valid entries, including the head being popped this cycle.
  - lk_hit=1 if any valid entry has addr==lk_addr.
  - lk_data = data of the youngest such entry; otherwise lk_data=0.

Optional Feature:
- Macro: WB_SEQ_LOOKUP_EN.
- Defined: the lookup comparators are built and lk_hit/lk_data behave as above.
- Undefined: the comparators are not built; lk_hit=0 and lk_data=0 constantly, and lk_addr is ignored.

Decomposition:
- Shared package holds:
  - REG_IDX_W=2
  - a wb_entry_t struct {addr[1:0], data[DATA_W-1:0]}
  - occupancy state constants EMPTY/PARTIAL/FULL
- One natural sub-module: wb_fifo_ptr, which handles the pointer/count update, the full/empty flags and wrap. The storage array and lookup stay in the top module.

Test Plan:
- Reset then idle: count=0, in_ready=1, wr_en=0, wr_addr=0 → decoder output 4'b1111.
- Push (addr=2, data=8'hA5) at edge 1, hold=0 → wr_en=1, wr_addr=2, wr_data=8'hA5 in cycle after edge 1; count back to 0 after edge 2.
- Hold=1, push (1,8'h11) and (3,8'h33) → count=2, in_ready=0, wr_en=0. Third push is not accepted. Drop hold → issues 1/8'h11 then 3/8'h33 in consecutive cycles.
- Continuous push every cycle with hold=0, addrs 0,1,2,3 → count stays ≤1, each write issued exactly once, in order; pointer wrap is exercised.
- Lookup (WB_SEQ_LOOKUP_EN, hold=1): pending (2,8'h01) then (2,8'h02), lk_addr=2 → lk_hit=1, lk_data=8'h02. With lk_addr=0 → lk_hit=0, lk_data=0.
- Reset asserted mid-cycle with count=2 → outputs go to reset values asynchronously. After release, no stale write is issued.
